// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with status port, sticky error flags and RTS hysteresis
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 4
) (
  input  logic                clk28,
  input  logic                rst_n,
  input  logic                en,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  input  logic                rx_frame_err,
  input  logic                rd_data_req,
  input  logic                rd_stat_req,
  input  logic                wr_ctrl_req,
  input  logic [7:0]          wr_ctrl_data,
  output logic [7:0]          d_out,
  output logic                d_out_active,
  output logic                uart_rts,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_CMAX = LW'(15);
  localparam logic [LW-1:0]         LVL_HI   = LW'(RTS_HIGH);
  localparam logic [LW-1:0]         LVL_LO   = LW'(RTS_LOW);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d, frm_q, frm_d;
  logic [7:0]            d_out_q, d_out_d;
  logic                  act_q, act_d, rts_q, rts_d;

  logic empty, full, push_req, pop_req, push_ok, pop_ok, flush, clr, ovf_evt;
  logic [3:0] stat_cnt;
  logic unused_ctrl;

  assign unused_ctrl = ^wr_ctrl_data[7:2];

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_FULL);
  assign push_req = en & rx_valid;
  assign pop_req  = en & rd_data_req;
  assign pop_ok   = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req & (~full | pop_ok);
  assign ovf_evt  = push_req & full & ~pop_ok;
  assign flush    = en & wr_ctrl_req & wr_ctrl_data[0];
  assign clr      = en & wr_ctrl_req & wr_ctrl_data[1];
  assign stat_cnt = (level_q > LVL_CMAX) ? 4'hF : level_q[3:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = 1'b0;
    frm_d    = 1'b0;
    d_out_d  = d_out_q;
    act_d    = en & (rd_data_req | rd_stat_req);
    rts_d    = 1'b1;

    if (en) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
      end
      // New events take priority over a clear in the same cycle.
      ovf_d = (ovf_q & ~clr) | ovf_evt;
      frm_d = (frm_q & ~clr) | rx_frame_err;

      if (rd_data_req)      d_out_d = empty ? 8'hFF : mem[rd_ptr_q];
      else if (rd_stat_req) d_out_d = {stat_cnt, frm_q, ovf_q, full, ~empty};

      if (level_d >= LVL_HI)      rts_d = 1'b1;
      else if (level_d <= LVL_LO) rts_d = 1'b0;
      else                        rts_d = rts_q;
    end else begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      frm_q    <= 1'b0;
      d_out_q  <= 8'h00;
      act_q    <= 1'b0;
      rts_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      frm_q    <= frm_d;
      d_out_q  <= d_out_d;
      act_q    <= act_d;
      rts_q    <= rts_d;
    end
  end

  always_ff @(posedge clk28) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= rx_byte;
  end

  assign d_out        = d_out_q;
  assign d_out_active = act_q;
  assign uart_rts     = rts_q;
  assign level        = level_q;

endmodule
